// File: rtl/esdi_serial_xfer.sv
// esdi_serial_xfer: ESDI serial command/status engine.
// Sends a parity-protected command word, then reads back status words.
module esdi_serial_xfer #(
  parameter  int DATA_BITS      = 16,
  parameter  int MAX_STATUS     = 4,
  parameter  int SYNC_STAGES    = 2,
  parameter  int SETUP_CYCLES   = 4,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int NW = $clog2(MAX_STATUS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_BITS-1:0] cmd_data,
  input  logic [NW-1:0]        cmd_nstatus,
  output logic                 status_valid,
  output logic [DATA_BITS-1:0] status_data,
  output logic                 status_parity_err,
  output logic                 done,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 esdi_transfer_req,
  output logic                 esdi_command_data,
  input  logic                 esdi_transfer_ack,
  input  logic                 esdi_confstat_data
);
  localparam int BW = $clog2(DATA_BITS + 2);
  localparam int CW = $clog2(TIMEOUT_CYCLES + SETUP_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, C_SETUP, C_ACKH, C_ACKL,
    S_START, S_REQ, S_ACKH, S_ACKL, DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_q;
  logic [SYNC_STAGES-1:0] cst_q;
  logic                   ack_s;
  logic                   cst_s;
  logic [DATA_BITS:0]     sh;
  logic [DATA_BITS:0]     rx;
  logic [BW-1:0]          bitcnt;
  logic [NW-1:0]          wordcnt;
  logic [NW-1:0]          nstat;
  logic [NW-1:0]          nclamp;
  logic [CW-1:0]          cnt;
  logic                   waiting;
  logic                   expired;

  assign ack_s  = ack_q[SYNC_STAGES-1];
  assign cst_s  = cst_q[SYNC_STAGES-1];
  assign nclamp = (cmd_nstatus > NW'(MAX_STATUS)) ?
                  NW'(MAX_STATUS) : cmd_nstatus;

  // Bring the drive's asynchronous ack and data into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= '0;
      cst_q <= '0;
    end else begin
      ack_q <= {ack_q[SYNC_STAGES-2:0], esdi_transfer_ack};
      cst_q <= {cst_q[SYNC_STAGES-2:0], esdi_confstat_data};
    end
  end

  // Flag handshake states still waiting on the drive's ack edge.
  always_comb begin
    waiting = 1'b0;
    case (state)
      C_ACKH, S_ACKH: waiting = !ack_s;
      C_ACKL, S_ACKL: waiting = ack_s;
      default:        waiting = 1'b0;
    endcase
  end

  assign expired = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Transfer sequencer; every output is a flop so the pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      sh                <= '0;
      rx                <= '0;
      bitcnt            <= '0;
      wordcnt           <= '0;
      nstat             <= '0;
      cnt               <= '0;
      cmd_ready         <= 1'b1;
      status_valid      <= 1'b0;
      status_data       <= '0;
      status_parity_err <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
      busy              <= 1'b0;
      esdi_transfer_req <= 1'b0;
      esdi_command_data <= 1'b0;
    end else begin
      status_valid      <= 1'b0;
      status_parity_err <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
      if (expired) begin
        esdi_transfer_req <= 1'b0;
        esdi_command_data <= 1'b0;
        timeout_err       <= 1'b1;
        cmd_ready         <= 1'b1;
        busy              <= 1'b0;
        cnt               <= '0;
        state             <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              sh                <= {cmd_data, ~^cmd_data};
              esdi_command_data <= cmd_data[DATA_BITS-1];
              nstat             <= nclamp;
              bitcnt            <= '0;
              wordcnt           <= '0;
              cnt               <= '0;
              cmd_ready         <= 1'b0;
              busy              <= 1'b1;
              state             <= C_SETUP;
            end
          end
          C_SETUP: begin
            if (cnt == CW'(SETUP_CYCLES - 1)) begin
              esdi_transfer_req <= 1'b1;
              cnt               <= '0;
              state             <= C_ACKH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          C_ACKH: begin
            if (ack_s) begin
              esdi_transfer_req <= 1'b0;
              cnt               <= '0;
              state             <= C_ACKL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          C_ACKL: begin
            if (!ack_s) begin
              sh     <= {sh[DATA_BITS-1:0], 1'b0};
              bitcnt <= bitcnt + 1'b1;
              cnt    <= '0;
              if (bitcnt == BW'(DATA_BITS)) begin
                esdi_command_data <= 1'b0;
                state <= (nstat != '0) ? S_START : DONE;
              end else begin
                esdi_command_data <= sh[DATA_BITS-1];
                state             <= C_SETUP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_START: begin
            esdi_command_data <= 1'b0;
            wordcnt           <= wordcnt + 1'b1;
            bitcnt            <= '0;
            cnt               <= '0;
            state             <= S_REQ;
          end
          S_REQ: begin
            esdi_transfer_req <= 1'b1;
            cnt               <= '0;
            state             <= S_ACKH;
          end
          S_ACKH: begin
            if (ack_s) begin
              rx                <= {rx[DATA_BITS-1:0], cst_s};
              esdi_transfer_req <= 1'b0;
              bitcnt            <= bitcnt + 1'b1;
              cnt               <= '0;
              state             <= S_ACKL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_ACKL: begin
            if (!ack_s) begin
              cnt <= '0;
              if (bitcnt == BW'(DATA_BITS + 1)) begin
                status_data       <= rx[DATA_BITS:1];
                status_parity_err <= ~^rx;
                status_valid      <= 1'b1;
                state <= (wordcnt < nstat) ? S_START : DONE;
              end else begin
                state <= S_REQ;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_esdi_serial_xfer.sv
// tb_esdi_serial_xfer: scoreboard bench for esdi_serial_xfer.
// A drive model answers handshakes; a monitor checks status words.
`timescale 1ns/1ps
module tb_esdi_serial_xfer;
  localparam int DB = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DB-1:0] cmd_data = '0;
  logic [2:0]    cmd_nstatus = '0;
  logic          status_valid;
  logic [DB-1:0] status_data;
  logic          status_parity_err;
  logic          done;
  logic          timeout_err;
  logic          busy;
  logic          req;
  logic          cdata;
  logic          ack = 1'b0;
  logic          cst = 1'b0;

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int req_total = 0;
  int sv_cnt = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  bit drv_en = 1'b1;

  logic          exp_cmd[$];
  logic          drv_bits[$];
  logic [DB:0]   exp_status[$];

  always #5 clk = ~clk;

  esdi_serial_xfer #(
    .DATA_BITS(DB), .MAX_STATUS(4), .SYNC_STAGES(2),
    .SETUP_CYCLES(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_nstatus(cmd_nstatus),
    .status_valid(status_valid), .status_data(status_data),
    .status_parity_err(status_parity_err),
    .done(done), .timeout_err(timeout_err), .busy(busy),
    .esdi_transfer_req(req), .esdi_command_data(cdata),
    .esdi_transfer_ack(ack), .esdi_confstat_data(cst)
  );

  task automatic push_cmd(input logic [DB-1:0] d, input logic p);
    for (int i = DB - 1; i >= 0; i--) exp_cmd.push_back(d[i]);
    exp_cmd.push_back(p);
  endtask

  task automatic push_word(input logic [DB-1:0] w, input logic p,
                           input logic err);
    for (int i = DB - 1; i >= 0; i--) drv_bits.push_back(w[i]);
    drv_bits.push_back(p);
    exp_status.push_back({err, w});
  endtask

  task automatic send(input logic [DB-1:0] d, input logic [2:0] ns);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_data    = d;
    cmd_nstatus = ns;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_monitor();
    logic [DB:0] e;
    forever begin
      @(negedge clk);
      if (status_valid) begin
        sv_cnt++;
        tests++;
        if (exp_status.size() == 0) begin
          fails++;
          $display("FAIL status_extra: got %h err %b, expected none",
                   status_data, status_parity_err);
        end else begin
          e = exp_status.pop_front();
          if ({status_parity_err, status_data} !== e) begin
            fails++;
            $display("FAIL status_word: got err %b data %h, want err %b data %h",
                     status_parity_err, status_data, e[DB], e[DB-1:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        req_cnt = 0;
        tests++;
        if (status_valid !== 1'b0) begin
          fails++;
          $display("FAIL done_overlap: status_valid %b with done, want 0",
                   status_valid);
        end
      end
      if (timeout_err) begin
        to_cnt++;
        req_cnt = 0;
      end
    end
  endtask

  task automatic run_drive();
    logic b;
    logic nb;
    forever begin
      @(negedge clk);
      if (drv_en && req && !ack) begin
        req_cnt++;
        req_total++;
        nb = 1'b0;
        if (req_cnt <= DB + 1) begin
          tests++;
          if (exp_cmd.size() == 0) begin
            fails++;
            $display("FAIL cmd_extra: bit %b sent, none expected", cdata);
          end else begin
            b = exp_cmd.pop_front();
            if (cdata !== b) begin
              fails++;
              $display("FAIL cmd_bit %0d: got %b, want %b", req_cnt, cdata, b);
            end
          end
        end else if (drv_bits.size() != 0) begin
          nb = drv_bits.pop_front();
        end
        repeat (3) @(negedge clk);
        cst = nb;
        ack = 1'b1;
        for (int i = 0; i < 300 && req; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        ack = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, want 1", cmd_ready);
    end
    tests++;
    if ({busy, req, cdata} !== 3'b000) begin
      fails++;
      $display("FAIL reset_pins: busy/req/cdata %b, want 000",
               {busy, req, cdata});
    end
    tests++;
    if ({done, status_valid, timeout_err, status_parity_err} !== 4'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b, want 0000",
               {done, status_valid, timeout_err, status_parity_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: ready/busy %b, want 10",
               {cmd_ready, busy});
    end
  endtask

  task automatic test_cmd_only();
    int t0 = req_total;
    int s0 = sv_cnt;
    bit ok;
    push_cmd(16'h1234, 1'b0);
    send(16'h1234, 3'd0);
    wait_done(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cmd_only_done: no done within budget, want done");
    end
    tests++;
    if (req_total - t0 != DB + 1) begin
      fails++;
      $display("FAIL cmd_only_reqs: got %0d, want 17", req_total - t0);
    end
    tests++;
    if (sv_cnt != s0 || exp_cmd.size() != 0) begin
      fails++;
      $display("FAIL cmd_only_rest: status %0d left %0d, want 0 0",
               sv_cnt - s0, exp_cmd.size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_status();
    int s0 = sv_cnt;
    bit ok;
    push_cmd(16'h0F00, 1'b1);
    push_word(16'hA5A5, 1'b1, 1'b0);
    send(16'h0F00, 3'd1);
    wait_done(ok);
    tests++;
    if (!ok || sv_cnt - s0 != 1) begin
      fails++;
      $display("FAIL single_status: done %b words %0d, want 1 1",
               ok, sv_cnt - s0);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bad_parity();
    int s0 = sv_cnt;
    bit ok;
    push_cmd(16'h0F00, 1'b1);
    push_word(16'hA5A5, 1'b0, 1'b1);
    push_word(16'h1234, 1'b0, 1'b0);
    push_word(16'hFFFF, 1'b1, 1'b0);
    send(16'h0F00, 3'd3);
    wait_done(ok);
    tests++;
    if (!ok || sv_cnt - s0 != 3 || exp_status.size() != 0) begin
      fails++;
      $display("FAIL bad_parity: done %b words %0d left %0d, want 1 3 0",
               ok, sv_cnt - s0, exp_status.size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int e0 = to_cnt;
    int hi = 0;
    drv_en = 1'b0;
    send(16'h5555, 3'd0);
    for (int i = 0; i < 50 && !req; i++) @(negedge clk);
    while (req && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    tests++;
    if (hi != TO) begin
      fails++;
      $display("FAIL timeout_len: req high %0d cycles, want %0d", hi, TO);
    end
    tests++;
    if ({timeout_err, cmd_ready, busy} !== 3'b110) begin
      fails++;
      $display("FAIL timeout_flags: err/ready/busy %b, want 110",
               {timeout_err, cmd_ready, busy});
    end
    repeat (10) @(negedge clk);
    tests++;
    if (done_cnt != d0 || to_cnt - e0 != 1) begin
      fails++;
      $display("FAIL timeout_pulses: done %0d timeouts %0d, want 0 1",
               done_cnt - d0, to_cnt - e0);
    end
    drv_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int s0;
    bit ok;
    bit hit = 1'b0;
    push_cmd(16'h0F00, 1'b1);
    push_word(16'hA5A5, 1'b1, 1'b0);
    send(16'h0F00, 3'd1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_cnt >= DB + 6 && req) begin
        hit = 1'b1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_reach: status bit 5 not reached, want reached");
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (req !== 1'b0) begin
      fails++;
      $display("FAIL mid_req_drop: req %b during reset, want 0", req);
    end
    tests++;
    if ({cdata, cmd_ready, busy, status_valid} !== 4'b0100) begin
      fails++;
      $display("FAIL mid_outputs: cdata/ready/busy/sv %b, want 0100",
               {cdata, cmd_ready, busy, status_valid});
    end
    exp_status.delete();
    drv_bits.delete();
    exp_cmd.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    req_cnt = 0;
    s0 = sv_cnt;
    push_cmd(16'h8001, 1'b1);
    push_word(16'hBEEF, 1'b0, 1'b0);
    send(16'h8001, 3'd1);
    wait_done(ok);
    tests++;
    if (!ok || sv_cnt - s0 != 1) begin
      fails++;
      $display("FAIL mid_recover: done %b words %0d, want 1 1",
               ok, sv_cnt - s0);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s0 = sv_cnt;
    int acc = 0;
    int bad = 0;
    bit got = 1'b0;
    bit ok;
    push_cmd(16'hC3A5, 1'b1);
    push_word(16'h0001, 1'b0, 1'b0);
    push_word(16'h7FFF, 1'b0, 1'b0);
    push_word(16'h8000, 1'b0, 1'b0);
    push_word(16'hBEEF, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_data    = 16'hC3A5;
    cmd_nstatus = 3'd7;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (cmd_valid && cmd_ready) acc++;
      if (busy && cmd_ready) bad++;
      @(negedge clk);
    end
    tests++;
    if (!got || acc != 1 || bad != 0) begin
      fails++;
      $display("FAIL b2b_first: done %b accepts %0d ready-while-busy %0d, want 1 1 0",
               got, acc, bad);
    end
    tests++;
    if (sv_cnt - s0 != 4 || exp_status.size() != 0) begin
      fails++;
      $display("FAIL b2b_clamp: words %0d left %0d, want 4 0",
               sv_cnt - s0, exp_status.size());
    end
    push_cmd(16'h00FF, 1'b1);
    cmd_data    = 16'h00FF;
    cmd_nstatus = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if ({busy, cmd_ready} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_second_accept: busy/ready %b, want 10",
               {busy, cmd_ready});
    end
    wait_done(ok);
    tests++;
    if (!ok || exp_cmd.size() != 0 || sv_cnt - s0 != 4) begin
      fails++;
      $display("FAIL b2b_second_done: done %b left %0d words %0d, want 1 0 4",
               ok, exp_cmd.size(), sv_cnt - s0);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    fork
      run_monitor();
      run_drive();
    join_none
    test_reset();
    test_cmd_only();
    test_single_status();
    test_bad_parity();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/esdi_serial_xfer.md
Name: esdi_serial_xfer

Overview:
- Parametrised ESDI serial command/status engine that replaces the fixed single-word TRANSFER_REQ/TRANSFER_ACK sequencer.
- Shifts one 16-bit command word plus an odd-parity bit to the drive on COMMAND_DATA, then reads back 0..N configuration/status words on CONFIG_STATUS_DATA.
- Adds input synchronisation, per-bit handshake timeout, status parity checking and multi-word status reads.
- Sits between the SoC register block and the ESDI drive pins. Outputs are active-high; the pin-level inversion stays at top level.

Parameters:
- DATA_BITS, 16, payload bits per command/status word; parity bit is appended as bit DATA_BITS+1.
- MAX_STATUS, 4, maximum status words read per command.
- SYNC_STAGES, 2, flop stages on esdi_transfer_ack and esdi_confstat_data (minimum 2).
- SETUP_CYCLES, 4, clk cycles esdi_command_data is stable before esdi_transfer_req rises.
- TIMEOUT_CYCLES, 65535, clk cycles allowed per handshake edge before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid&&cmd_ready.
- cmd_data  in  DATA_BITS  command word, sent MSB first.
- cmd_nstatus  in  clog2(MAX_STATUS+1)  status words to read after the command.
- status_valid  out  1  one-cycle pulse per received status word.
- status_data  out  DATA_BITS  received word; held until the next word.
- status_parity_err  out  1  qualifies status_valid; the received parity bit is wrong.
- done  out  1  one-cycle pulse on normal completion.
- timeout_err  out  1  one-cycle pulse on abort.
- busy  out  1  high when not IDLE.
- esdi_transfer_req  out  1  handshake request to drive.
- esdi_command_data  out  1  serial command bit.
- esdi_transfer_ack  in  1  drive acknowledge (asynchronous).
- esdi_confstat_data  in  1  drive serial status bit (asynchronous).

Behaviour:
- Reset values: all registered outputs 0, cmd_ready=1, state IDLE, counters 0. Asynchronous assert; synchronous release on the next clk edge.
- Synchronisers: ack_s and cst_s are SYNC_STAGES-deep. All FSM decisions use only the synchronised values.
- IDLE:
  - cmd_ready=1.
  - On accept: latch {cmd_data, parity} into a (DATA_BITS+1)-bit shift register. Parity = ~^cmd_data (odd parity: total ones odd).
  - Latch cmd_nstatus, clamped to MAX_STATUS. bitcnt=0. Go to C_SETUP.
  - cmd_ready drops the cycle after accept.
- C_SETUP: esdi_command_data=shift MSB; wait SETUP_CYCLES; then req=1, go to C_ACKH.
- C_ACKH: wait ack_s=1; then req=0, go to C_ACKL.
- C_ACKL:
  - Wait ack_s=0; then shift left and bitcnt++.
  - If bitcnt was DATA_BITS (last bit sent): go to S_START if nstatus>0, else DONE.
  - Otherwise go to C_SETUP.
- S_START: esdi_command_data=0, wordcnt++, bitcnt=0; go to S_REQ.
- S_REQ: req=1; go to S_ACKH.
- S_ACKH: wait ack_s=1; sample cst_s into the receive shift register (MSB first); req=0; go to S_ACKL.
- S_ACKL:
  - Wait ack_s=0. If DATA_BITS+1 bits are not yet received, go to S_REQ.
  - Otherwise: status_data=rx[DATA_BITS:1]; status_parity_err=(^rx==0); pulse status_valid.
  - Then go to S_START if wordcnt<nstatus, else DONE.
- DONE: pulse done for 1 cycle; go to IDLE. done and the final status_valid are never in the same cycle.
- Timeout:
  - Counter clears on every state entry and counts in C_ACKH, C_ACKL, S_ACKH and S_ACKL.
  - When count reaches TIMEOUT_CYCLES-1: req=0, command_data=0, pulse timeout_err, go to IDLE.
  - No done pulse; partial status words are discarded.
- A parity error does not abort the transfer; remaining words are still read.
- cmd_valid while busy is ignored; there is no queue.
- cmd_nstatus=0 is a command-only transfer.
- rst mid-transfer drops req immediately (asynchronous). The drive-side handshake is left to the drive to time out.
- esdi_transfer_req and esdi_command_data are driven directly from flops (glitch-free).

Test Plan:
- Command-only: cmd_data=0x1234, nstatus=0, drive model ACKs after 3 clk. Expect 17 req pulses, bits 0001_0010_0011_0100 then parity 0 (popcount 5), done=1 once, no status_valid.
- Single status: cmd 0x0F00, nstatus=1, drive returns 0xA5A5 with parity bit 1. Expect status_valid once, status_data=0xA5A5, status_parity_err=0, then done.
- Bad parity: as above but drive returns 0xA5A5 with parity 0, nstatus=3. Expect parity_err=1 on word 1, words 2 and 3 still received, done pulses.
- Timeout: TIMEOUT_CYCLES=100, drive never ACKs. Expect req high for exactly 100 cycles, then req=0, timeout_err pulse, cmd_ready=1, no done.
- Reset mid-transfer: assert rst during status bit 5. Expect req=0 asynchronously, all outputs at reset values; a new command after release completes normally.
- Back-to-back and clamp: cmd_valid held high with nstatus=7 (MAX_STATUS=4). Expect cmd_ready low while busy, exactly 4 words read, second command accepted only after done.
